// File: rtl/rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_grant_arbiter
//  Description : 4-way round-robin arbiter with registered one-hot grant,
//                grant enable, owner index and hold-limit timeout pulse.
//                A grant ends on owner release, owner request drop or hold
//                limit, and is always followed by at least one idle cycle.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_grant_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 15,
   parameter int IDW      = 2
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [N-1:0]   req,
   // "release" is a reserved word in SystemVerilog, hence this port name
   input  logic           owner_release,
   output logic [N-1:0]   grant,
   output logic           grant_en,
   output logic [IDW-1:0] owner_id,
   output logic           timeout
);

   // Hold counter must represent MAX_HOLD itself; keep at least one bit.
   localparam int CW = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
   localparam logic [CW-1:0] HOLD_LIM = CW'(MAX_HOLD);
   localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

   typedef enum logic [0:0] {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t          state;
   logic [IDW-1:0]  pointer;
   logic [CW-1:0]   hold_cnt;

   logic [IDW-1:0]  sel;
   logic            sel_valid;
   logic            exit_rel;
   logic            exit_drop;
   logic            exit_hold;
   logic [IDW-1:0]  next_pointer;

   // Pick the first requester at or after the pointer, wrapping at N-1.
   // The scan runs from the farthest offset down so the nearest one wins.
   always_comb begin
      sel       = '0;
      sel_valid = 1'b0;
      for (int k = N - 1; k >= 0; k--) begin
         if (req[IDW'((int'(pointer) + k) % N)]) begin
            sel       = IDW'((int'(pointer) + k) % N);
            sel_valid = 1'b1;
         end
      end
   end

   // Grant termination conditions and the rotated pointer for the next round.
   always_comb begin
      exit_rel     = owner_release;
      exit_drop    = ~req[owner_id];
      exit_hold    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LIM);
      next_pointer = (owner_id == IDW'(N - 1)) ? '0 : owner_id + IDW'(1);
   end

   // Arbiter state machine; every output is registered here.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         grant    <= '0;
         grant_en <= 1'b0;
         owner_id <= '0;
         timeout  <= 1'b0;
         pointer  <= '0;
         hold_cnt <= '0;
      end else begin
         case (state)
            IDLE: begin
               timeout <= 1'b0;
               if (sel_valid) begin
                  grant      <= '0;
                  grant[sel] <= 1'b1;
                  grant_en   <= 1'b1;
                  owner_id   <= sel;
                  hold_cnt   <= CW'(1);
                  state      <= GRANT;
               end
            end
            GRANT: begin
               if (exit_rel || exit_drop || exit_hold) begin
                  grant    <= '0;
                  grant_en <= 1'b0;
                  pointer  <= next_pointer;
                  hold_cnt <= '0;
                  // Release and request drop take precedence over the limit.
                  timeout  <= exit_hold && !exit_rel && !exit_drop;
                  state    <= IDLE;
               end else if (hold_cnt != CNT_MAX) begin
                  hold_cnt <= hold_cnt + CW'(1);
               end
            end
            default: begin
               state    <= IDLE;
               grant    <= '0;
               grant_en <= 1'b0;
               timeout  <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_rr_grant_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_grant_arbiter
//  Description : Bench for rr_grant_arbiter: directed scenarios followed by
//                random request/release traffic against a reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_grant_arbiter;

   localparam int N        = 4;
   localparam int MAX_HOLD = 4;
   localparam int IDW      = 2;

   logic           clk;
   logic           rst;
   logic [N-1:0]   req;
   logic           owner_release;
   logic [N-1:0]   grant;
   logic           grant_en;
   logic [IDW-1:0] owner_id;
   logic           timeout;

   int checks;
   int fails;

   // Reference model state: whether someone holds the resource, who,
   // for how many visible cycles, where the next scan starts, and the pulse.
   bit m_busy;
   int m_owner;
   int m_age;
   int m_ptr;
   bit m_to;

   rr_grant_arbiter #(.N(N), .MAX_HOLD(MAX_HOLD), .IDW(IDW)) dut (
      .clk           (clk),
      .rst           (rst),
      .req           (req),
      .owner_release (owner_release),
      .grant         (grant),
      .grant_en      (grant_en),
      .owner_id      (owner_id),
      .timeout       (timeout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic model_reset();
      m_busy  = 0;
      m_owner = 0;
      m_age   = 0;
      m_ptr   = 0;
      m_to    = 0;
   endtask

   // One clock edge of the arbitration rules, using the inputs seen at the edge.
   task automatic model_clock();
      bit done_rel, done_drop, done_hold;
      if (m_busy) begin
         done_rel  = owner_release;
         done_drop = (req[m_owner] == 1'b0);
         done_hold = (MAX_HOLD != 0) && (m_age == MAX_HOLD);
         if (done_rel || done_drop || done_hold) begin
            m_busy = 0;
            m_ptr  = (m_owner + 1) % N;
            m_to   = done_hold && !done_rel && !done_drop;
         end else begin
            m_age++;
            m_to = 0;
         end
      end else begin
         m_to = 0;
         for (int off = 0; off < N; off++) begin
            if (!m_busy && req[(m_ptr + off) % N]) begin
               m_busy  = 1;
               m_owner = (m_ptr + off) % N;
               m_age   = 1;
            end
         end
      end
   endtask

   task automatic check_outputs(input string tag);
      logic [N-1:0]   exp_grant;
      logic [IDW-1:0] exp_owner;
      logic           oh;
      exp_grant = '0;
      if (m_busy) exp_grant[m_owner] = 1'b1;
      exp_owner = IDW'(m_owner);
      oh = ($countones(grant) == 1);

      checks++;
      assert (grant === exp_grant) else begin
         fails++;
         $error("FAIL %s grant: got %b expected %b", tag, grant, exp_grant);
      end
      checks++;
      assert (grant_en === logic'(m_busy)) else begin
         fails++;
         $error("FAIL %s grant_en: got %b expected %b", tag, grant_en, m_busy);
      end
      checks++;
      assert (owner_id === exp_owner) else begin
         fails++;
         $error("FAIL %s owner_id: got %0d expected %0d", tag, owner_id, exp_owner);
      end
      checks++;
      assert (timeout === logic'(m_to)) else begin
         fails++;
         $error("FAIL %s timeout: got %b expected %b", tag, timeout, m_to);
      end
      checks++;
      assert (oh === grant_en) else begin
         fails++;
         $error("FAIL %s one_hot_vs_en: got one_hot=%b expected %b", tag, oh, grant_en);
      end
   endtask

   // Directed literal expectations, independent of the model.
   task automatic expect_gt(input string tag, input logic [N-1:0] g, input logic t);
      checks++;
      assert (grant === g) else begin
         fails++;
         $error("FAIL %s grant_directed: got %b expected %b", tag, grant, g);
      end
      checks++;
      assert (timeout === t) else begin
         fails++;
         $error("FAIL %s timeout_directed: got %b expected %b", tag, timeout, t);
      end
   endtask

   task automatic step(input logic [N-1:0] r, input logic rl, input string tag);
      @(negedge clk);
      req           = r;
      owner_release = rl;
      @(posedge clk);
      model_clock();
      #1;
      check_outputs(tag);
   endtask

   initial begin
      logic [N-1:0] seq2 [8];
      logic [N-1:0] rr;
      checks = 0;
      fails  = 0;
      rst           = 1'b1;
      req           = '0;
      owner_release = 1'b0;
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      check_outputs("reset");

      @(negedge clk);
      rst = 1'b0;

      // 1: single requester, one-edge latency
      step(4'b0001, 1'b0, "t1_grant");
      expect_gt("t1_grant", 4'b0001, 1'b0);
      step(4'b0001, 1'b1, "t1_release");

      // 2: all requesting, release one cycle after each grant
      seq2 = '{4'b0010, 4'b0000, 4'b0100, 4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
      for (int i = 0; i < 6; i++) begin
         step(4'b1111, logic'(i % 2), "t2_rr");
         expect_gt("t2_rr", seq2[i], 1'b0);
      end
      // 3: pointer wrapped to 0 after owner 3
      step(4'b1001, 1'b0, "t3_wrap");
      expect_gt("t3_wrap", 4'b0001, 1'b0);
      step(4'b1001, 1'b1, "t3_rel0");
      step(4'b1001, 1'b0, "t3_next");
      expect_gt("t3_next", 4'b1000, 1'b0);
      step(4'b1001, 1'b1, "t3_rel3");

      // 4: hold limit, then release on the last allowed cycle
      for (int i = 0; i < 4; i++) begin
         step(4'b0100, 1'b0, "t4_hold");
         expect_gt("t4_hold", 4'b0100, 1'b0);
      end
      step(4'b0100, 1'b0, "t4_timeout");
      expect_gt("t4_timeout", 4'b0000, 1'b1);
      step(4'b0100, 1'b0, "t4_regrant");
      expect_gt("t4_regrant", 4'b0100, 1'b0);
      for (int i = 0; i < 3; i++) step(4'b0100, 1'b0, "t4_hold2");
      step(4'b0100, 1'b1, "t4_rel_wins");
      expect_gt("t4_rel_wins", 4'b0000, 1'b0);

      // 5: owner drops its request mid-grant
      step(4'b0010, 1'b0, "t5_grant");
      expect_gt("t5_grant", 4'b0010, 1'b0);
      step(4'b0000, 1'b0, "t5_drop");
      expect_gt("t5_drop", 4'b0000, 1'b0);
      step(4'b1001, 1'b0, "t5_ptr2");
      expect_gt("t5_ptr2", 4'b1000, 1'b0);

      // 6: asynchronous reset between edges while granted
      #2;
      rst = 1'b1;
      req = '0;
      #1;
      model_reset();
      check_outputs("t6_async_rst");
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk);
      model_clock();
      #1;
      check_outputs("t6_idle");
      step(4'b1010, 1'b0, "t6_ptr0");
      expect_gt("t6_ptr0", 4'b0010, 1'b0);
      step(4'b1010, 1'b1, "t6_rel");

      // Random traffic; the owner usually keeps its request to exercise holds.
      for (int i = 0; i < 400; i++) begin
         rr = N'($urandom);
         if (($urandom % 4) != 0) rr = rr | grant;
         step(rr, logic'(($urandom % 5) == 0), "rand");
      end

      $display("%0d/%0d checks passed", checks - fails, checks);
      $finish;
   end

endmodule
`default_nettype wire
